// File: rtl/ram_arbiter.sv
// Single-port work RAM arbiter: CPU, display-burst and DMA requesters share one
// 1-cycle-latency RAM; fixed priority with a CPU anti-starvation counter.
module ram_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int VID_BURST  = 8,
  parameter int CPU_STARVE = 4,
  localparam int LEN_W     = $clog2(VID_BURST) + 1
) (
  input  logic              CLK,
  input  logic              RST,
  // Handshake: a requester holds req with stable fields until its gnt pulse;
  // gnt means the access was issued to RAM that cycle, read data follows one
  // cycle later with rvalid. Writes never produce rvalid.
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic [LEN_W-1:0]  vid_len,
  output logic              vid_gnt,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int WAIT_W = $clog2(CPU_STARVE + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   base_q;
  logic [LEN_W-1:0]    beat_q;
  logic [LEN_W-1:0]    len_q;
  logic [WAIT_W-1:0]   wait_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic                ram_we_q;
  logic [DATA_W-1:0]   ram_wdata_q;
  logic                cpu_gnt_q;
  logic                dma_gnt_q;
  logic                vid_gnt_q;
  logic                cpu_rv_q;
  logic                dma_rv_q;
  logic                vid_beat_q;
  logic                vid_last_q;
  logic                vid_rv_q;
  logic                vid_done_q;

  logic                cpu_elig;
  logic                dma_elig;
  logic                vid_elig;
  logic                cpu_first;
  logic                win_cpu;
  logic                win_vid;
  logic                win_dma;
  logic [LEN_W-1:0]    len_eff;

  // A requester whose gnt is high this cycle is still holding the old request.
  always_comb begin
    cpu_elig  = cpu_req & ~cpu_gnt_q;
    dma_elig  = dma_req & ~dma_gnt_q;
    vid_elig  = vid_req & ~vid_gnt_q;
    cpu_first = (wait_q >= WAIT_W'(CPU_STARVE));
    win_cpu   = cpu_elig & (cpu_first | ~vid_elig);
    win_vid   = vid_elig & ~win_cpu;
    win_dma   = dma_elig & ~cpu_elig & ~vid_elig;
  end

  always_comb begin
    len_eff = vid_len;
    if (vid_len == '0) begin
      len_eff = LEN_W'(1);
    end else if (vid_len > LEN_W'(VID_BURST)) begin
      len_eff = LEN_W'(VID_BURST);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      base_q      <= '0;
      beat_q      <= '0;
      len_q       <= '0;
      wait_q      <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      cpu_gnt_q   <= 1'b0;
      dma_gnt_q   <= 1'b0;
      vid_gnt_q   <= 1'b0;
      cpu_rv_q    <= 1'b0;
      dma_rv_q    <= 1'b0;
      vid_beat_q  <= 1'b0;
      vid_last_q  <= 1'b0;
      vid_rv_q    <= 1'b0;
      vid_done_q  <= 1'b0;
    end else begin
      cpu_gnt_q  <= 1'b0;
      dma_gnt_q  <= 1'b0;
      vid_gnt_q  <= 1'b0;
      ram_we_q   <= 1'b0;
      vid_beat_q <= 1'b0;
      vid_last_q <= 1'b0;

      // Read-return pipeline: the access issued last cycle has data now.
      cpu_rv_q   <= cpu_gnt_q & ~ram_we_q;
      dma_rv_q   <= dma_gnt_q & ~ram_we_q;
      vid_rv_q   <= vid_beat_q;
      vid_done_q <= vid_last_q;

      if (!cpu_req || cpu_gnt_q) begin
        wait_q <= '0;
      end else if (wait_q < WAIT_W'(CPU_STARVE)) begin
        wait_q <= wait_q + WAIT_W'(1);
      end

      case (state_q)
        IDLE: begin
          if (win_cpu) begin
            ram_addr_q  <= cpu_addr;
            ram_we_q    <= cpu_we;
            ram_wdata_q <= cpu_wdata;
            cpu_gnt_q   <= 1'b1;
          end else if (win_vid) begin
            ram_addr_q <= vid_addr;
            vid_gnt_q  <= 1'b1;
            vid_beat_q <= 1'b1;
            base_q     <= vid_addr;
            len_q      <= len_eff;
            beat_q     <= LEN_W'(1);
            if (len_eff == LEN_W'(1)) begin
              vid_last_q <= 1'b1;
            end else begin
              state_q <= BURST;
            end
          end else if (win_dma) begin
            ram_addr_q  <= dma_addr;
            ram_we_q    <= dma_we;
            ram_wdata_q <= dma_wdata;
            dma_gnt_q   <= 1'b1;
          end
        end
        BURST: begin
          // Beat addresses wrap naturally at the top of the address space.
          ram_addr_q <= base_q + ADDR_W'(beat_q);
          vid_beat_q <= 1'b1;
          beat_q     <= beat_q + LEN_W'(1);
          if (beat_q == len_q - LEN_W'(1)) begin
            vid_last_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ram_addr   = ram_addr_q;
  assign ram_we     = ram_we_q;
  assign ram_wdata  = ram_wdata_q;
  assign cpu_gnt    = cpu_gnt_q;
  assign dma_gnt    = dma_gnt_q;
  assign vid_gnt    = vid_gnt_q;
  assign cpu_rvalid = cpu_rv_q;
  assign dma_rvalid = dma_rv_q;
  assign vid_rvalid = vid_rv_q;
  assign vid_done   = vid_done_q;
  // Read data is gated so every output is zero outside a valid return.
  assign cpu_rdata  = cpu_rv_q ? ram_rdata : '0;
  assign dma_rdata  = dma_rv_q ? ram_rdata : '0;
  assign vid_rdata  = vid_rv_q ? ram_rdata : '0;

  a_one_gnt: assert property (@(posedge CLK) disable iff (RST)
    $onehot0({cpu_gnt_q, dma_gnt_q, vid_gnt_q}));

  a_burst_excl: assert property (@(posedge CLK) disable iff (RST)
    (state_q == BURST) |-> !(cpu_gnt_q || dma_gnt_q));

endmodule
